// File: rtl/put_pkg.sv
// Shared definitions for the operand put sequencer.
package put_pkg;
  localparam int W      = 8;
  localparam int MAXOPS = 3;
  localparam int IDXW   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUT  = 2'd1,
    OP   = 2'd2
  } state_e;
endpackage

// File: rtl/put_sequencer.sv
// Issues up to three latched operand beats, then one operate beat, to an accumulator.
// Outputs are combinational from state and acc_ready; acc_ready low stalls in place.
module put_sequencer #(
  parameter int W      = 8,
  parameter int MAXOPS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_count,
  input  logic [W-1:0] req_op0,
  input  logic [W-1:0] req_op1,
  input  logic [W-1:0] req_op2,
  input  logic         acc_ready,
  output logic         putEn,
  output logic         opEn,
  output logic [W-1:0] value,
  input  logic         flush,
  output logic         busy,
  output logic         seq_done
);
  import put_pkg::*;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [W-1:0]    ops_q [MAXOPS];
  logic [W-1:0]    ops_d [MAXOPS];
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < MAXOPS; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < MAXOPS; i++) ops_q[i] <= ops_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    for (int i = 0; i < MAXOPS; i++) ops_d[i] = ops_q[i];

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          cnt_d    = req_count;
          ops_d[0] = req_op0;
          ops_d[1] = req_op1;
          ops_d[2] = req_op2;
          idx_d    = '0;
          state_d  = (req_count != 2'd0) ? PUT : OP;
        end
      end
      PUT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (acc_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == cnt_q - 2'd1) state_d = OP;
        end
      end
      OP: begin
        if (flush) begin
          state_d = IDLE;
        end else if (acc_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An aborted sequence leaves nothing behind for the next request to see.
    if (flush && state_q != IDLE) begin
      idx_d = '0;
      cnt_d = '0;
      for (int i = 0; i < MAXOPS; i++) ops_d[i] = '0;
    end
  end

  always_comb begin
    value = '0;
    if (state_q == PUT) value = ops_q[idx_q];
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign putEn     = (state_q == PUT) && acc_ready;
  // Operate beat is withheld while flushing so an aborted sequence never operates.
  assign opEn      = (state_q == OP) && acc_ready && !flush;
  assign seq_done  = done_q;
endmodule

// File: tb/tb_put_sequencer.sv
// Randomized and directed bench comparing put_sequencer to a queue-based transaction model.
module tb_put_sequencer;
  logic       clk = 1'b0;
  logic       reset, req_valid, acc_ready, flush;
  logic       req_ready, putEn, opEn, busy, seq_done;
  logic [1:0] req_count;
  logic [7:0] req_op0, req_op1, req_op2, value;

  put_sequencer #(.W(8), .MAXOPS(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_count(req_count), .req_op0(req_op0), .req_op1(req_op1), .req_op2(req_op2),
    .acc_ready(acc_ready), .putEn(putEn), .opEn(opEn), .value(value),
    .flush(flush), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending operand bytes plus an outstanding operate beat.
  logic [7:0] pend[$];
  bit         op_pend = 1'b0;
  bit         done_m  = 1'b0;
  bit         chk_en  = 1'b0;

  // Observation trackers used by the directed scenarios.
  int         cyc_no = 0;
  int         op_cyc = -1;
  int         done_cyc = -1;
  int         acc_q[$];
  logic [7:0] beats_q[$];
  logic [7:0] last_val;
  bit         last_rdy;

  task automatic cyc(input bit rv, input logic [1:0] cnt, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input bit ar, input bit fl, input bit rst);
    bit         m_busy, e_put, e_op;
    logic [7:0] e_val;
    @(negedge clk);
    req_valid = rv; req_count = cnt; req_op0 = a; req_op1 = b; req_op2 = c;
    acc_ready = ar; flush = fl; reset = rst;
    cyc_no++;
    #1;
    m_busy = (pend.size() > 0) || op_pend;
    e_put  = (pend.size() > 0) && ar;
    e_val  = (pend.size() > 0) ? pend[0] : 8'h00;
    e_op   = (pend.size() == 0) && op_pend && ar && !fl;
    if (chk_en) begin
      chk("putEn", {31'd0, putEn}, {31'd0, e_put});
      chk("opEn", {31'd0, opEn}, {31'd0, e_op});
      chk("value", {24'd0, value}, {24'd0, e_val});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
      chk("seq_done", {31'd0, seq_done}, {31'd0, done_m});
      chk("exclusive", {31'd0, putEn & opEn}, 32'd0);
    end
    last_val = value;
    last_rdy = req_ready;
    if (putEn) beats_q.push_back(value);
    if (opEn) op_cyc = cyc_no;
    if (seq_done) done_cyc = cyc_no;
    if (req_ready && rv && !fl && !rst) acc_q.push_back(cyc_no);
    @(posedge clk);
    done_m = 1'b0;
    if (rst) begin
      pend.delete(); op_pend = 1'b0;
    end else if (m_busy && fl) begin
      pend.delete(); op_pend = 1'b0;
    end else if (m_busy) begin
      if (pend.size() > 0) begin
        if (ar) void'(pend.pop_front());
      end else if (ar) begin
        op_pend = 1'b0; done_m = 1'b1;
      end
    end else if (rv && !fl) begin
      if (cnt > 0) pend.push_back(a);
      if (cnt > 1) pend.push_back(b);
      if (cnt > 2) pend.push_back(c);
      op_pend = 1'b1;
    end
  endtask

  task automatic clr_obs();
    op_cyc = -1; done_cyc = -1; acc_q.delete(); beats_q.delete();
  endtask

  task automatic idle(input int n, input bit ar);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, ar, 0, 0);
  endtask

  int a0;

  initial begin
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 1);
    chk_en = 1'b1;
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 1);
    idle(2, 1);

    // Scenario 1: three operands, acc_ready held high.
    clr_obs();
    cyc(1, 2'd3, 8'h11, 8'h22, 8'h33, 1, 0, 0);
    a0 = cyc_no;
    idle(6, 1);
    chk("s1_nbeats", beats_q.size(), 3);
    if (beats_q.size() == 3) begin
      chk("s1_b0", {24'd0, beats_q[0]}, 32'h11);
      chk("s1_b1", {24'd0, beats_q[1]}, 32'h22);
      chk("s1_b2", {24'd0, beats_q[2]}, 32'h33);
    end
    chk("s1_op_cyc", op_cyc - a0, 4);
    chk("s1_done_cyc", done_cyc - a0, 5);

    // Scenario 2: zero operands.
    clr_obs();
    cyc(1, 2'd0, 8'h55, 8'h66, 8'h77, 1, 0, 0);
    a0 = cyc_no;
    idle(3, 1);
    chk("s2_nbeats", beats_q.size(), 0);
    chk("s2_op_cyc", op_cyc - a0, 1);

    // Scenario 3: stall after the first beat.
    clr_obs();
    cyc(1, 2'd2, 8'h11, 8'h22, 8'h99, 1, 0, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 0, 0, 0);
      chk("s3_hold", {24'd0, last_val}, 32'h22);
    end
    idle(3, 1);
    chk("s3_nbeats", beats_q.size(), 2);
    if (beats_q.size() == 2) chk("s3_b1", {24'd0, beats_q[1]}, 32'h22);

    // Scenario 4: flush on the second beat.
    clr_obs();
    cyc(1, 2'd3, 8'h11, 8'h22, 8'h33, 1, 0, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 1, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 0);
    chk("s4_ready", {31'd0, last_rdy}, 32'd1);
    idle(3, 1);
    chk("s4_no_op", op_cyc, -1);
    chk("s4_no_done", done_cyc, -1);

    // Scenario 5: back-to-back requests with req_valid held.
    clr_obs();
    cyc(1, 2'd1, 8'hA1, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'd2, 8'hB1, 8'hB2, 8'h00, 1, 0, 0);
    idle(5, 1);
    chk("s5_naccepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) chk("s5_gap", acc_q[1] - acc_q[0], 3);
    chk("s5_nbeats", beats_q.size(), 3);
    if (beats_q.size() == 3) begin
      chk("s5_b0", {24'd0, beats_q[0]}, 32'hA1);
      chk("s5_b2", {24'd0, beats_q[2]}, 32'hB2);
    end

    // Scenario 6: reset while waiting in OP.
    clr_obs();
    cyc(1, 2'd1, 8'h42, 8'h00, 8'h00, 1, 0, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 1, 0, 0);
    cyc(0, 2'd0, 8'h0, 8'h0, 8'h0, 0, 0, 1);
    idle(4, 1);
    chk("s6_no_op", op_cyc, -1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
